mem_tile_reader: RTL and testbench

MEM_TILE_READER -- requirements
Module: mem_tile_reader

---
 rtl/mem_tile_reader_pkg.sv | 21 ++
 rtl/mem_tile_reader_if.sv | 25 ++
 rtl/mem_tile_reader.sv | 160 ++++++++++++++++
 tb/tb_mem_tile_reader.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_tile_reader_pkg.sv
// mem_tile_reader_pkg: shared FSM state type and default geometry for the tile reader.
package mem_tile_reader_pkg;

  // Address width needed to index 'depth' entries; a single-entry memory still gets one bit.
  function automatic int unsigned addr_width_for(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  localparam int unsigned DefNumPorts  = 4;
  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefDataDepth = 4096;
  localparam int unsigned DefRowWidth  = 16;
  localparam int unsigned DefAddrWidth = addr_width_for(DefDataDepth);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2
  } state_e;

endpackage

// File: rtl/mem_tile_reader_if.sv
// mem_tile_reader_if: memory read port plus the row output stream of mem_tile_reader.
// master = the reader, slave = memory/consumer side.
interface mem_tile_reader_if #(
  parameter int unsigned NumPorts  = mem_tile_reader_pkg::DefNumPorts,
  parameter int unsigned DataWidth = mem_tile_reader_pkg::DefDataWidth,
  parameter int unsigned AddrWidth = mem_tile_reader_pkg::DefAddrWidth
);
  logic        [AddrWidth-1:0] mem_addr_o    [NumPorts];
  logic                        mem_we_o      [NumPorts];
  logic signed [DataWidth-1:0] mem_wr_data_o [NumPorts];
  logic signed [DataWidth-1:0] mem_rd_data_i [NumPorts];
  logic signed [DataWidth-1:0] data_o        [NumPorts];
  logic                        valid_o;
  logic                        ready_i;

  modport master (
    output mem_addr_o, mem_we_o, mem_wr_data_o, data_o, valid_o,
    input  mem_rd_data_i, ready_i
  );

  modport slave (
    input  mem_addr_o, mem_we_o, mem_wr_data_o, data_o, valid_o,
    output mem_rd_data_i, ready_i
  );
endinterface

// File: rtl/mem_tile_reader.sv
// mem_tile_reader: reads num_rows rows of NumPorts adjacent words (row start advancing by
// stride) from a combinational-read memory and streams them out with valid/ready.
// Optional lane range check is built when MEM_TILE_READER_BOUNDS_CHECK_EN is defined;
// it adds err_o.
//
// state     | meaning
// ----------+------------------------------------------------------------------
// ST_IDLE   | waiting for start_i; memory address parked at 0
// ST_STREAM | rows still to capture; a row is captured whenever the slot is free
// ST_FLUSH  | every row captured; waiting for the final beat's handshake
module mem_tile_reader
  import mem_tile_reader_pkg::*;
#(
  parameter int unsigned NumPorts  = DefNumPorts,
  parameter int unsigned DataWidth = DefDataWidth,
  parameter int unsigned DataDepth = DefDataDepth,
  parameter int unsigned AddrWidth = addr_width_for(DataDepth),
  parameter int unsigned RowWidth  = DefRowWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [AddrWidth-1:0] stride_i,
  input  logic [RowWidth-1:0]  num_rows_i,
  output logic                 busy_o,
  output logic                 done_o,
`ifdef MEM_TILE_READER_BOUNDS_CHECK_EN
  output logic                 err_o,
`endif
  mem_tile_reader_if.master    bus
);

  state_e                      state_q;
  logic        [AddrWidth-1:0] row_addr_q;
  logic        [AddrWidth-1:0] stride_q;
  logic        [RowWidth-1:0]  rows_left_q;
  logic        [AddrWidth-1:0] addr_q  [NumPorts];
  logic signed [DataWidth-1:0] data_q  [NumPorts];
  logic signed [DataWidth-1:0] rd_lane [NumPorts];
  logic                        valid_q;
  logic                        busy_q;
  logic                        zero_done_q;
  logic                        slot_free;
  logic        [AddrWidth-1:0] next_row;
`ifdef MEM_TILE_READER_BOUNDS_CHECK_EN
  logic                        err_q;
  logic                        range_hit;
`endif

  assign slot_free = !valid_q || bus.ready_i;
  assign next_row  = row_addr_q + stride_q;

  // Per-lane read data; with the range check built in, lanes past the memory read as 0.
  always_comb begin
`ifdef MEM_TILE_READER_BOUNDS_CHECK_EN
    range_hit = 1'b0;
`endif
    for (int i = 0; i < int'(NumPorts); i++) begin
      rd_lane[i] = bus.mem_rd_data_i[i];
`ifdef MEM_TILE_READER_BOUNDS_CHECK_EN
      if (32'(addr_q[i]) >= DataDepth) begin
        rd_lane[i] = '0;
        range_hit  = 1'b1;
      end
`endif
    end
  end

  // Sequencer: command latch, row capture into the output slot, lane address generation.
  // Lane addresses are registered so they only move on a capture and stay put while stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      row_addr_q  <= '0;
      stride_q    <= '0;
      rows_left_q <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      zero_done_q <= 1'b0;
`ifdef MEM_TILE_READER_BOUNDS_CHECK_EN
      err_q       <= 1'b0;
`endif
      for (int i = 0; i < int'(NumPorts); i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      zero_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
`ifdef MEM_TILE_READER_BOUNDS_CHECK_EN
            err_q <= 1'b0;
`endif
            if (num_rows_i != '0) begin
              state_q     <= ST_STREAM;
              busy_q      <= 1'b1;
              row_addr_q  <= base_addr_i;
              stride_q    <= stride_i;
              rows_left_q <= num_rows_i;
              for (int i = 0; i < int'(NumPorts); i++) begin
                addr_q[i] <= base_addr_i + AddrWidth'(i);
              end
            end else begin
              // Empty command: completion pulse only, never busy.
              zero_done_q <= 1'b1;
            end
          end
        end
        ST_STREAM: begin
          if (slot_free) begin
            valid_q     <= 1'b1;
            row_addr_q  <= next_row;
            rows_left_q <= rows_left_q - RowWidth'(1);
            for (int i = 0; i < int'(NumPorts); i++) begin
              data_q[i] <= rd_lane[i];
              addr_q[i] <= next_row + AddrWidth'(i);
            end
`ifdef MEM_TILE_READER_BOUNDS_CHECK_EN
            if (range_hit) err_q <= 1'b1;
`endif
            if (rows_left_q == RowWidth'(1)) state_q <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (bus.ready_i) begin
            state_q    <= ST_IDLE;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            row_addr_q <= '0;
            for (int i = 0; i < int'(NumPorts); i++) begin
              addr_q[i] <= '0;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // done_o fires in the same cycle as the final handshake, or one cycle after an empty start.
  assign done_o      = zero_done_q || ((state_q == ST_FLUSH) && bus.ready_i);
  assign busy_o      = busy_q;
  assign bus.valid_o = valid_q;
`ifdef MEM_TILE_READER_BOUNDS_CHECK_EN
  assign err_o       = err_q;
`endif

  // Drive the interface lanes; the write side of the memory port is tied off.
  always_comb begin
    for (int i = 0; i < int'(NumPorts); i++) begin
      bus.mem_addr_o[i]    = addr_q[i];
      bus.data_o[i]        = data_q[i];
      bus.mem_we_o[i]      = 1'b0;
      bus.mem_wr_data_o[i] = '0;
    end
  end

endmodule

// File: tb/tb_mem_tile_reader.sv
// tb_mem_tile_reader: directed vector table, multi-cycle corner sequences and randomized
// commands checked against a row-list model of the reader. Define
// MEM_TILE_READER_BOUNDS_CHECK_EN to also exercise err_o with DataDepth=4000.
module tb_mem_tile_reader;
  localparam int NP = 4;
  localparam int DW = 8;
  localparam int AW = 12;
  localparam int RW = 16;
`ifdef MEM_TILE_READER_BOUNDS_CHECK_EN
  localparam int DEPTH = 4000;
`else
  localparam int DEPTH = 4096;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base;
  logic [AW-1:0] stride;
  logic [RW-1:0] rows;
  logic          busy;
  logic          done;
`ifdef MEM_TILE_READER_BOUNDS_CHECK_EN
  logic          err;
`endif

  int total = 0;
  int bad   = 0;

  logic signed [DW-1:0] mem [1 << AW];

  mem_tile_reader_if #(.NumPorts(NP), .DataWidth(DW), .AddrWidth(AW)) bus ();

  mem_tile_reader #(
    .NumPorts(NP), .DataWidth(DW), .DataDepth(DEPTH), .AddrWidth(AW), .RowWidth(RW)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .start_i(start),
    .base_addr_i(base),
    .stride_i(stride),
    .num_rows_i(rows),
    .busy_o(busy),
    .done_o(done),
`ifdef MEM_TILE_READER_BOUNDS_CHECK_EN
    .err_o(err),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Combinational-read memory behind the reader.
  always_comb begin
    for (int i = 0; i < NP; i++) bus.mem_rd_data_i[i] = mem[bus.mem_addr_o[i]];
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  // Reference model: row k, lane i lives at base + k*stride + i (mod 2^AW); out-of-range reads 0.
  function automatic logic [AW-1:0] lane_addr(input int b, input int k, input int s, input int lane);
    return AW'(b + k * s + lane);
  endfunction

  function automatic logic signed [DW-1:0] model_data(input logic [AW-1:0] a);
    if (int'(a) >= DEPTH) return '0;
    return mem[a];
  endfunction

  function automatic logic ready_for(input int mode, input int cyc);
    if (mode == 1) return !(cyc >= 3 && cyc <= 5);
    if (mode == 2) return ($urandom_range(0, 3) != 0);
    return 1'b1;
  endfunction

  // One command from IDLE to one idle cycle after done_o, checked cycle by cycle.
  // mode 0: ready always high, 1: ready low in cycles 3-5, 2: random ready plus junk starts.
  task automatic run_cmd(input string tag, input logic [AW-1:0] b, input logic [AW-1:0] s,
                         input logic [RW-1:0] n, input int mode);
    int hs = 0;
    int captured;
    int done_cyc = -1;
    int budget = 10 * int'(n) + 20;
    bit done_seen = 0;
    bit active, exp_valid, exp_done, hsk;
    bit prev_stall = 0;
    logic signed [DW-1:0] prev_data [NP];
    logic [AW-1:0] exp_a;
    start = 1'b1; base = b; stride = s; rows = n;
    bus.ready_i = ready_for(mode, 0);
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      active    = (n != 0) && (cyc >= 1) && !done_seen;
      exp_valid = active && (cyc >= 2);
      hsk       = exp_valid && bus.ready_i;
      exp_done  = (n == 0) ? (cyc == 1) : (hsk && (hs == int'(n) - 1));
      chk($sformatf("%s c%0d valid", tag, cyc), 32'(bus.valid_o), 32'(exp_valid));
      chk($sformatf("%s c%0d busy", tag, cyc), 32'(busy), 32'(active));
      chk($sformatf("%s c%0d done", tag, cyc), 32'(done), 32'(exp_done));
      captured = hs + (exp_valid ? 1 : 0);
      for (int i = 0; i < NP; i++) begin
        exp_a = active ? lane_addr(int'(b), captured, int'(s), i) : '0;
        chk($sformatf("%s c%0d addr%0d", tag, cyc, i), 32'(bus.mem_addr_o[i]), 32'(exp_a));
        if (prev_stall)
          chk($sformatf("%s c%0d hold%0d", tag, cyc, i), 32'(bus.data_o[i]), 32'(prev_data[i]));
        if (hsk)
          chk($sformatf("%s beat%0d lane%0d", tag, hs, i), 32'(bus.data_o[i]),
              32'(model_data(lane_addr(int'(b), hs, int'(s), i))));
        prev_data[i] = bus.data_o[i];
      end
      if (hsk) hs++;
      prev_stall = exp_valid && !bus.ready_i;
      if (exp_done) begin
        done_seen = 1;
        done_cyc  = cyc;
      end
      to_drive();
      start = 1'b0;
      if (done_seen && cyc > done_cyc) break;
      if (mode == 2) begin
        start  = (n != 0 && !done_seen) ? 1'($urandom_range(0, 1)) : 1'b0;
        base   = AW'($urandom);
        stride = AW'($urandom);
        rows   = RW'($urandom_range(0, 9));
      end
      bus.ready_i = ready_for(mode, cyc + 1);
    end
    start = 1'b0;
    chk($sformatf("%s completed", tag), 32'(done_seen), 32'(1));
    chk($sformatf("%s beat count", tag), 32'(hs), 32'(n));
  endtask

  typedef struct {
    logic          start;
    logic [AW-1:0] base;
    logic [AW-1:0] stride;
    logic [RW-1:0] rows;
    logic          ready;
    logic          e_valid;
    logic          e_busy;
    logic          e_done;
    logic [AW-1:0] e_a0;
    logic [AW-1:0] e_a3;
    int            e_row;   // lane-0 address of the row expected on data_o, -1 = not checked
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic st, input logic [AW-1:0] b, input logic [AW-1:0] s,
                              input logic [RW-1:0] n, input logic rdy, input logic ev,
                              input logic eb, input logic ed, input logic [AW-1:0] a0,
                              input logic [AW-1:0] a3, input int er);
    vec_t v;
    v.start = st; v.base = b; v.stride = s; v.rows = n; v.ready = rdy;
    v.e_valid = ev; v.e_busy = eb; v.e_done = ed; v.e_a0 = a0; v.e_a3 = a3; v.e_row = er;
    return v;
  endfunction

  initial begin
    // base=0x010 stride=4 rows=3: beats on cycles 2-4, done in cycle 4
    tbl.push_back(mk(1, 12'h010, 12'd4, 16'd3, 1, 0, 0, 0, 12'h000, 12'h000, -1));
    tbl.push_back(mk(0, 12'h000, 12'd0, 16'd0, 1, 0, 1, 0, 12'h010, 12'h013, -1));
    tbl.push_back(mk(0, 12'h000, 12'd0, 16'd0, 1, 1, 1, 0, 12'h014, 12'h017, 'h010));
    tbl.push_back(mk(0, 12'h000, 12'd0, 16'd0, 1, 1, 1, 0, 12'h018, 12'h01B, 'h014));
    tbl.push_back(mk(0, 12'h000, 12'd0, 16'd0, 1, 1, 1, 1, 12'h01C, 12'h01F, 'h018));
    tbl.push_back(mk(0, 12'h000, 12'd0, 16'd0, 1, 0, 0, 0, 12'h000, 12'h000, -1));
    // rows=0: done pulse in cycle 1 only
    tbl.push_back(mk(1, 12'h123, 12'd5, 16'd0, 1, 0, 0, 0, 12'h000, 12'h000, -1));
    tbl.push_back(mk(0, 12'h000, 12'd0, 16'd0, 1, 0, 0, 1, 12'h000, 12'h000, -1));
    tbl.push_back(mk(0, 12'h000, 12'd0, 16'd0, 1, 0, 0, 0, 12'h000, 12'h000, -1));
    // base=0xFFE stride=2 rows=2: lane addresses wrap through 0
    tbl.push_back(mk(1, 12'hFFE, 12'd2, 16'd2, 1, 0, 0, 0, 12'h000, 12'h000, -1));
    tbl.push_back(mk(0, 12'h000, 12'd0, 16'd0, 1, 0, 1, 0, 12'hFFE, 12'h001, -1));
    tbl.push_back(mk(0, 12'h000, 12'd0, 16'd0, 1, 1, 1, 0, 12'h000, 12'h003, 'hFFE));
    tbl.push_back(mk(0, 12'h000, 12'd0, 16'd0, 1, 1, 1, 1, 12'h002, 12'h005, 'h000));
    tbl.push_back(mk(0, 12'h000, 12'd0, 16'd0, 1, 0, 0, 0, 12'h000, 12'h000, -1));

    for (int a = 0; a < (1 << AW); a++) mem[a] = DW'($urandom);

    // Reset: outputs zero, start held during reset is discarded.
    rst_n = 1'b0; start = 1'b1; base = 12'h100; stride = 12'd1; rows = 16'd3; bus.ready_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset valid", 32'(bus.valid_o), 32'(0));
    chk("reset busy", 32'(busy), 32'(0));
    chk("reset done", 32'(done), 32'(0));
    for (int i = 0; i < NP; i++) begin
      chk($sformatf("reset addr%0d", i), 32'(bus.mem_addr_o[i]), 32'(0));
      chk($sformatf("reset data%0d", i), 32'(bus.data_o[i]), 32'(0));
      chk($sformatf("we%0d", i), 32'(bus.mem_we_o[i]), 32'(0));
      chk($sformatf("wr_data%0d", i), 32'(bus.mem_wr_data_o[i]), 32'(0));
    end
    to_drive();
    start = 1'b0;
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post-reset busy", 32'(busy), 32'(0));
    chk("post-reset valid", 32'(bus.valid_o), 32'(0));
    chk("post-reset done", 32'(done), 32'(0));
    to_drive();

    // Directed vector table, one entry per cycle.
    for (int k = 0; k < tbl.size(); k++) begin
      start = tbl[k].start; base = tbl[k].base; stride = tbl[k].stride;
      rows = tbl[k].rows; bus.ready_i = tbl[k].ready;
      @(negedge clk);
      chk($sformatf("tbl%0d valid", k), 32'(bus.valid_o), 32'(tbl[k].e_valid));
      chk($sformatf("tbl%0d busy", k), 32'(busy), 32'(tbl[k].e_busy));
      chk($sformatf("tbl%0d done", k), 32'(done), 32'(tbl[k].e_done));
      chk($sformatf("tbl%0d addr0", k), 32'(bus.mem_addr_o[0]), 32'(tbl[k].e_a0));
      chk($sformatf("tbl%0d addr3", k), 32'(bus.mem_addr_o[3]), 32'(tbl[k].e_a3));
      if (tbl[k].e_row >= 0)
        for (int i = 0; i < NP; i++)
          chk($sformatf("tbl%0d data%0d", k, i), 32'(bus.data_o[i]),
              32'(model_data(AW'(tbl[k].e_row + i))));
      to_drive();
    end
    start = 1'b0;

    // Back-pressure in cycles 3-5 with four rows.
    run_cmd("stall", 12'h200, 12'd8, 16'd4, 1);

    // Reset while the second of five beats is on the output.
    start = 1'b1; base = 12'h300; stride = 12'd16; rows = 16'd5; bus.ready_i = 1'b1;
    to_drive();
    start = 1'b0;
    to_drive();
    to_drive();
    chk("midrst valid before", 32'(bus.valid_o), 32'(1));
    chk("midrst busy before", 32'(busy), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("midrst valid", 32'(bus.valid_o), 32'(0));
    chk("midrst busy", 32'(busy), 32'(0));
    chk("midrst done", 32'(done), 32'(0));
    for (int i = 0; i < NP; i++) begin
      chk($sformatf("midrst addr%0d", i), 32'(bus.mem_addr_o[i]), 32'(0));
      chk($sformatf("midrst data%0d", i), 32'(bus.data_o[i]), 32'(0));
    end
    to_drive();
    rst_n = 1'b1;
    @(negedge clk);
    chk("after midrst done", 32'(done), 32'(0));
    chk("after midrst busy", 32'(busy), 32'(0));
    to_drive();
    run_cmd("after reset", 12'h040, 12'd4, 16'd5, 0);

`ifdef MEM_TILE_READER_BOUNDS_CHECK_EN
    run_cmd("bounds", 12'd3998, 12'd1, 16'd1, 0);
    chk("bounds err set", 32'(err), 32'(1));
    run_cmd("bounds clear", 12'd0, 12'd1, 16'd1, 0);
    chk("bounds err cleared", 32'(err), 32'(0));
`endif

    // Randomized commands, random back-pressure and start strobes while busy.
    for (int t = 0; t < 40; t++) begin
      run_cmd($sformatf("rnd%0d", t), AW'($urandom), AW'($urandom),
              RW'(($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 12)),
              ($urandom_range(0, 3) == 0) ? 0 : 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
